// File: rtl/fsm_driver.sv
// fsm_driver: command-driven pulse generator for the INIT/RUNNING control FSM.
// A host command supplies a run length, a gap length and a burst count. The
// block emits start/stop pulses (downstream in0/in1), mirrors the downstream
// state, and reports completion or abort with a one-cycle done pulse.
module fsm_driver #(
  parameter int CNT_W = 16,
  parameter int REP_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_run_len,
  input  logic [CNT_W-1:0] cmd_gap_len,
  input  logic [REP_W-1:0] cmd_count,
  input  logic             abort,
  output logic             start,
  output logic             stop,
  output logic             mirror_state,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [REP_W-1:0] bursts_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_STOP  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t state;
  state_t state_nx;

  // Latched command fields; zero run length and count are stored as 1.
  logic [CNT_W-1:0] run_len;
  logic [CNT_W-1:0] gap_len;
  logic [REP_W-1:0] count;

  // Shared down-counter for the RUNNING phase and the idle gap.
  logic [CNT_W-1:0] cnt;

  // Abort seen in START/RUN; honoured once the pending stop pulse is out.
  logic abort_pend;

  logic accept;
  logic finish;
  logic finish_abort;
  logic last_burst;

  // Next-state decode and Moore/handshake outputs.
  always_comb begin
    state_nx     = state;
    cmd_ready    = 1'b0;
    start        = 1'b0;
    stop         = 1'b0;
    accept       = 1'b0;
    finish       = 1'b0;
    finish_abort = 1'b0;
    last_burst   = (REP_W'(bursts_done + 1'b1) == count);
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept   = 1'b1;
          state_nx = S_START;
        end
      end
      S_START: begin
        start = 1'b1;
        // run_len - 1 == 0 means the burst is a single RUNNING cycle.
        if (abort || run_len == CNT_W'(1)) state_nx = S_STOP;
        else                               state_nx = S_RUN;
      end
      S_RUN: begin
        if (abort || cnt == CNT_W'(1)) state_nx = S_STOP;
      end
      S_STOP: begin
        stop = 1'b1;
        if (last_burst || abort_pend || abort) begin
          state_nx     = S_IDLE;
          finish       = 1'b1;
          finish_abort = abort_pend | abort;
        end else if (gap_len == '0) begin
          state_nx = S_START;
        end else begin
          state_nx = S_GAP;
        end
      end
      S_GAP: begin
        // Downstream is already in INIT here, so abort needs no stop pulse.
        if (abort) begin
          state_nx     = S_IDLE;
          finish       = 1'b1;
          finish_abort = 1'b1;
        end else if (cnt == CNT_W'(1)) begin
          state_nx = S_START;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // Control state: FSM, mirror of downstream state, status and burst tally.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= S_IDLE;
      mirror_state <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      abort_pend   <= 1'b0;
      bursts_done  <= '0;
    end else begin
      state <= state_nx;
      done  <= finish;
      if (start)     mirror_state <= 1'b1;
      else if (stop) mirror_state <= 1'b0;
      if (accept) begin
        bursts_done <= '0;
        aborted     <= 1'b0;
        abort_pend  <= 1'b0;
      end else begin
        if (stop) bursts_done <= REP_W'(bursts_done + 1'b1);
        if (abort && (state == S_START || state == S_RUN)) abort_pend <= 1'b1;
        if (finish) aborted <= finish_abort;
      end
    end
  end

  // Datapath: command field capture and the run/gap down-counter.
  always_ff @(posedge clk) begin
    if (accept) begin
      run_len <= (cmd_run_len == '0) ? CNT_W'(1) : cmd_run_len;
      gap_len <= cmd_gap_len;
      count   <= (cmd_count == '0) ? REP_W'(1) : cmd_count;
    end
    if (start) begin
      cnt <= run_len - CNT_W'(1);
    end else if (stop) begin
      cnt <= gap_len;
    end else if (state == S_RUN || state == S_GAP) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fsm_driver.sv
// Scoreboard bench for fsm_driver: stimulus pushes expected start/stop/done
// events with their cycle numbers; a monitor pops and compares each event the
// DUT produces, and tracks a reference downstream INIT/RUNNING FSM.
module tb_fsm_driver;
  localparam int CNT_W = 8;
  localparam int REP_W = 8;

  logic             clk;
  logic             rstn;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_run_len;
  logic [CNT_W-1:0] cmd_gap_len;
  logic [REP_W-1:0] cmd_count;
  logic             abort;
  logic             start;
  logic             stop;
  logic             mirror_state;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [REP_W-1:0] bursts_done;

  fsm_driver #(.CNT_W(CNT_W), .REP_W(REP_W)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_run_len (cmd_run_len),
    .cmd_gap_len (cmd_gap_len),
    .cmd_count   (cmd_count),
    .abort       (abort),
    .start       (start),
    .stop        (stop),
    .mirror_state(mirror_state),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .bursts_done (bursts_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: value seen at a negedge names the current clock period.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference downstream FSM: INIT(0) -> RUNNING(1) on in0, back on in1.
  logic ref_state = 1'b0;
  always @(posedge clk) begin
    if (!rstn)      ref_state <= 1'b0;
    else if (start) ref_state <= 1'b1;
    else if (stop)  ref_state <= 1'b0;
  end

  typedef struct {
    int   cyc;
    int   kind;   // 0 start, 1 stop, 2 done
    logic ab;
    int   bd;
  } ev_t;

  ev_t expq[$];
  int  checks   = 0;
  int  failures = 0;
  bit  chk_en   = 1'b0;

  function automatic void exp_ev(input int c, input int k, input logic ab, input int bd);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    e.ab   = ab;
    e.bd   = bd;
    expq.push_back(e);
  endfunction

  task automatic check_ev(input int k);
    ev_t e;
    checks++;
    if (expq.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event kind=%0d at cyc=%0d, required no event", k, cyc);
    end else begin
      e = expq.pop_front();
      if (e.cyc != cyc || e.kind != k ||
          (k == 2 && (aborted !== e.ab || bursts_done !== REP_W'(e.bd)))) begin
        failures++;
        $display("FAIL event got kind=%0d cyc=%0d aborted=%b bursts=%0d, required kind=%0d cyc=%0d aborted=%b bursts=%0d",
                 k, cyc, aborted, bursts_done, e.kind, e.cyc, e.ab, e.bd);
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (start) check_ev(0);
        if (stop)  check_ev(1);
        if (done)  check_ev(2);
        checks++;
        if (mirror_state !== ref_state) begin
          failures++;
          $display("FAIL mirror cyc=%0d got=%b required=%b", cyc, mirror_state, ref_state);
        end
        checks++;
        if (cmd_ready !== ~busy || (start && stop)) begin
          failures++;
          $display("FAIL ready_busy cyc=%0d ready=%b busy=%b start=%b stop=%b, required ready=~busy and no start&stop",
                   cyc, cmd_ready, busy, start, stop);
        end
      end
    end
  endtask

  task automatic check_reset(input string nm);
    checks++;
    if ({cmd_ready, start, stop, mirror_state, busy, done, aborted} !== 7'b1000000 ||
        bursts_done !== '0 || ref_state !== 1'b0) begin
      failures++;
      $display("FAIL %s got rdy/start/stop/mir/busy/done/abt=%b bursts=%0d ref=%b, required 1000000 bursts=0 ref=0",
               nm, {cmd_ready, start, stop, mirror_state, busy, done, aborted}, bursts_done, ref_state);
    end
  endtask

  // Drive a command during the current period; it is accepted at the next edge.
  task automatic issue(input int run, input int gap, input int cnt, output int b);
    cmd_valid   = 1'b1;
    cmd_run_len = CNT_W'(run);
    cmd_gap_len = CNT_W'(gap);
    cmd_count   = REP_W'(cnt);
    b = cyc;
  endtask

  task automatic wait_done(input int limit, input string nm);
    int n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout done=%b after %0d cycles, required done=1", nm, done, n);
    end
  endtask

  initial begin
    int b;
    rstn        = 1'b0;
    cmd_valid   = 1'b0;
    cmd_run_len = '0;
    cmd_gap_len = '0;
    cmd_count   = '0;
    abort       = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    check_reset("init_reset");
    rstn   = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Two bursts, run 3, gap 2.
    issue(3, 2, 2, b);
    exp_ev(b + 1, 0, 1'b0, 0);
    exp_ev(b + 4, 1, 1'b0, 0);
    exp_ev(b + 7, 0, 1'b0, 0);
    exp_ev(b + 10, 1, 1'b0, 0);
    exp_ev(b + 11, 2, 1'b0, 2);
    @(negedge clk) cmd_valid = 1'b0;
    wait_done(40, "t1");
    repeat (3) @(negedge clk);

    // Abort during RUN of the first of three bursts.
    issue(5, 0, 3, b);
    exp_ev(b + 1, 0, 1'b0, 0);
    exp_ev(b + 3, 1, 1'b0, 0);
    exp_ev(b + 4, 2, 1'b1, 1);
    @(negedge clk) cmd_valid = 1'b0;
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    wait_done(20, "t3");
    repeat (8) @(negedge clk);

    // All-zero command behaves as run 1, count 1; aborted flag must clear.
    issue(0, 0, 0, b);
    exp_ev(b + 1, 0, 1'b0, 0);
    exp_ev(b + 2, 1, 1'b0, 0);
    exp_ev(b + 3, 2, 1'b0, 1);
    @(negedge clk) cmd_valid = 1'b0;
    wait_done(20, "t2");
    repeat (3) @(negedge clk);

    // Abort in the first gap: no stop issued, done the cycle after abort.
    issue(1, 4, 3, b);
    exp_ev(b + 1, 0, 1'b0, 0);
    exp_ev(b + 2, 1, 1'b0, 0);
    exp_ev(b + 4, 2, 1'b1, 1);
    @(negedge clk) cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    wait_done(20, "t4");
    checks++;
    if (mirror_state !== 1'b0) begin
      failures++;
      $display("FAIL t4_mirror got=%b required=0", mirror_state);
    end
    repeat (8) @(negedge clk);

    // Reset in cycle 3 of a run-10 burst.
    issue(10, 0, 1, b);
    exp_ev(b + 1, 0, 1'b0, 0);
    @(negedge clk) cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk) rstn = 1'b0;
    @(negedge clk);
    check_reset("t5_reset");
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // Normal command after reset: run 2, gap 1, two bursts.
    issue(2, 1, 2, b);
    exp_ev(b + 1, 0, 1'b0, 0);
    exp_ev(b + 3, 1, 1'b0, 0);
    exp_ev(b + 5, 0, 1'b0, 0);
    exp_ev(b + 7, 1, 1'b0, 0);
    exp_ev(b + 8, 2, 1'b0, 2);
    @(negedge clk) cmd_valid = 1'b0;
    wait_done(30, "t6");
    repeat (3) @(negedge clk);

    // cmd_valid held high: back-to-back accepts in each done cycle.
    issue(2, 0, 1, b);
    for (int k = 0; k < 3; k++) begin
      exp_ev(b + 1 + 4 * k, 0, 1'b0, 0);
      exp_ev(b + 3 + 4 * k, 1, 1'b0, 0);
      exp_ev(b + 4 + 4 * k, 2, 1'b0, 1);
    end
    repeat (12) @(negedge clk);
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);

    // Maximum run and gap lengths for CNT_W = 8.
    issue(255, 255, 2, b);
    exp_ev(b + 1, 0, 1'b0, 0);
    exp_ev(b + 256, 1, 1'b0, 0);
    exp_ev(b + 512, 0, 1'b0, 0);
    exp_ev(b + 767, 1, 1'b0, 0);
    exp_ev(b + 768, 2, 1'b0, 2);
    @(negedge clk) cmd_valid = 1'b0;
    wait_done(800, "t8");
    repeat (5) @(negedge clk);

    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL missing_events got=%0d outstanding, required 0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
